// File: rtl/lsu_mem_arbiter_if.sv
// rtl/lsu_mem_arbiter_if.sv - LSU request/response and shared memory port bundle
interface lsu_mem_arbiter_if #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic [NUM_LSUS-1:0]           lsu_read_valid;
    logic [NUM_LSUS*ADDR_BITS-1:0] lsu_read_address;
    logic [NUM_LSUS-1:0]           lsu_read_ready;
    logic [DATA_BITS-1:0]          lsu_read_data;
    logic [NUM_LSUS-1:0]           lsu_write_valid;
    logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address;
    logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data;
    logic [NUM_LSUS-1:0]           lsu_write_ready;

    logic                          mem_read_valid;
    logic [ADDR_BITS-1:0]          mem_read_address;
    logic                          mem_read_ready;
    logic [DATA_BITS-1:0]          mem_read_data;
    logic                          mem_write_valid;
    logic [ADDR_BITS-1:0]          mem_write_address;
    logic [DATA_BITS-1:0]          mem_write_data;
    logic                          mem_write_ready;

    modport master (
        input  lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address,
               lsu_write_data, mem_read_ready, mem_read_data, mem_write_ready,
        output lsu_read_ready, lsu_read_data, lsu_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );

    modport slave (
        output lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address,
               lsu_write_data, mem_read_ready, mem_read_data, mem_write_ready,
        input  lsu_read_ready, lsu_read_data, lsu_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory port among LSUs
module lsu_mem_arbiter #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    localparam int GIDX_BITS = $clog2(NUM_LSUS)
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_mem_arbiter_if.master    bus,
    output logic                 busy,
    output logic [GIDX_BITS-1:0] grant_idx
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

    localparam logic [GIDX_BITS:0]   NUM_W    = (GIDX_BITS+1)'(NUM_LSUS);
    localparam logic [GIDX_BITS-1:0] LAST_IDX = GIDX_BITS'(NUM_LSUS - 1);

    state_t                 state_q, state_d;
    logic [GIDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GIDX_BITS-1:0]   grant_idx_q, grant_idx_d;
    logic                   busy_q, busy_d;
    logic                   mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;
    logic [NUM_LSUS-1:0]    lsu_read_ready_q, lsu_read_ready_d;
    logic [NUM_LSUS-1:0]    lsu_write_ready_q, lsu_write_ready_d;
    logic [DATA_BITS-1:0]   lsu_read_data_q, lsu_read_data_d;

    logic                   found;
    logic [GIDX_BITS-1:0]   sel;
    logic [GIDX_BITS:0]     cand;

    // First requester at or after rr_ptr, wrapping modulo NUM_LSUS.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_LSUS; k++) begin
            cand = {1'b0, rr_ptr_q} + (GIDX_BITS+1)'(k);
            if (cand >= NUM_W) cand = cand - NUM_W;
            if (!found && (bus.lsu_read_valid[cand[GIDX_BITS-1:0]] ||
                           bus.lsu_write_valid[cand[GIDX_BITS-1:0]])) begin
                found = 1'b1;
                sel   = cand[GIDX_BITS-1:0];
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_idx_d         = grant_idx_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        lsu_read_ready_d    = '0;
        lsu_write_ready_d   = '0;
        lsu_read_data_d     = lsu_read_data_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_idx_d = sel;
                    // A simultaneous read and write from one LSU takes the read first.
                    if (bus.lsu_read_valid[sel]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = bus.lsu_read_address[sel*ADDR_BITS +: ADDR_BITS];
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = bus.lsu_write_address[sel*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = bus.lsu_write_data[sel*DATA_BITS +: DATA_BITS];
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    mem_read_valid_d              = 1'b0;
                    lsu_read_data_d               = bus.mem_read_data;
                    lsu_read_ready_d[grant_idx_q] = 1'b1;
                    rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
                    state_d  = DONE;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    mem_write_valid_d              = 1'b0;
                    lsu_write_ready_d[grant_idx_q] = 1'b1;
                    rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_idx_q         <= '0;
            busy_q              <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            lsu_read_ready_q    <= '0;
            lsu_write_ready_q   <= '0;
            lsu_read_data_q     <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_idx_q         <= grant_idx_d;
            busy_q              <= busy_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            lsu_read_ready_q    <= lsu_read_ready_d;
            lsu_write_ready_q   <= lsu_write_ready_d;
            lsu_read_data_q     <= lsu_read_data_d;
        end
    end

    assign busy                  = busy_q;
    assign grant_idx             = grant_idx_q;
    assign bus.mem_read_valid    = mem_read_valid_q;
    assign bus.mem_read_address  = mem_read_address_q;
    assign bus.mem_write_valid   = mem_write_valid_q;
    assign bus.mem_write_address = mem_write_address_q;
    assign bus.mem_write_data    = mem_write_data_q;
    assign bus.lsu_read_ready    = lsu_read_ready_q;
    assign bus.lsu_write_ready   = lsu_write_ready_q;
    assign bus.lsu_read_data     = lsu_read_data_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed vector bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_idx;

    int checks = 0;
    int errors = 0;

    lsu_mem_arbiter_if #(.NUM_LSUS(4), .ADDR_BITS(8), .DATA_BITS(16)) bus ();

    lsu_mem_arbiter #(.NUM_LSUS(4), .ADDR_BITS(8), .DATA_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  wv;
        int          delay;
        int          grant;
        bit          is_rd;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mdata(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {a, a ^ 8'h5A};
    endfunction

    task automatic run_vec(input vec_t v);
        int         n;
        logic [3:0] oh;
        oh = 4'(1) << v.grant;
        bus.lsu_read_valid  = v.rv;
        bus.lsu_write_valid = v.wv;
        n = 0;
        while (!(bus.mem_read_valid || bus.mem_write_valid) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=none expected=grant %0d", v.grant);
            return;
        end
        chk("grant_latency", n, 1);
        chk("grant_idx", {30'd0, grant_idx}, v.grant);
        chk("busy_wait", {31'd0, busy}, 1);
        chk("mem_read_valid", {31'd0, bus.mem_read_valid}, {31'd0, v.is_rd});
        chk("mem_write_valid", {31'd0, bus.mem_write_valid}, {31'd0, !v.is_rd});
        if (v.is_rd) chk("mem_read_address", {24'd0, bus.mem_read_address}, {24'd0, v.addr});
        else begin
            chk("mem_write_address", {24'd0, bus.mem_write_address}, {24'd0, v.addr});
            chk("mem_write_data", {16'd0, bus.mem_write_data}, {16'd0, v.data});
        end
        for (int d = 0; d < v.delay; d++) begin
            tick();
            chk("hold_valid", {31'd0, bus.mem_read_valid | bus.mem_write_valid}, 1);
            chk("hold_ready_low", {28'd0, bus.lsu_read_ready | bus.lsu_write_ready}, 0);
        end
        if (v.is_rd) begin
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = mdata(bus.mem_read_address);
        end else begin
            bus.mem_write_ready = 1'b1;
        end
        tick();
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        bus.mem_read_data   = 16'hDEAD;
        chk("lsu_read_ready", {28'd0, bus.lsu_read_ready}, v.is_rd ? {28'd0, oh} : 32'd0);
        chk("lsu_write_ready", {28'd0, bus.lsu_write_ready}, v.is_rd ? 32'd0 : {28'd0, oh});
        chk("mem_valid_cleared", {31'd0, bus.mem_read_valid | bus.mem_write_valid}, 0);
        if (v.is_rd) begin
            chk("lsu_read_data", {16'd0, bus.lsu_read_data}, {16'd0, v.data});
            bus.lsu_read_valid[v.grant] = 1'b0;
        end else begin
            bus.lsu_write_valid[v.grant] = 1'b0;
        end
        tick();
        chk("ready_one_cycle", {28'd0, bus.lsu_read_ready | bus.lsu_write_ready}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
        if (v.is_rd) chk("read_data_hold", {16'd0, bus.lsu_read_data}, {16'd0, v.data});
    endtask

    initial begin
        int         k;
        int         last;
        int         n;

        vt[0] = '{rv: 4'b0100, wv: 4'b0000, delay: 2, grant: 2, is_rd: 1, addr: 8'h10, data: 16'h1234};
        vt[1] = '{rv: 4'b1001, wv: 4'b0000, delay: 0, grant: 3, is_rd: 1, addr: 8'h33, data: 16'h3369};
        vt[2] = '{rv: 4'b0001, wv: 4'b0000, delay: 1, grant: 0, is_rd: 1, addr: 8'h40, data: 16'h401A};
        vt[3] = '{rv: 4'b0010, wv: 4'b0010, delay: 0, grant: 1, is_rd: 1, addr: 8'h05, data: 16'h055F};
        vt[4] = '{rv: 4'b0000, wv: 4'b0010, delay: 1, grant: 1, is_rd: 0, addr: 8'h06, data: 16'hBEEF};
        vt[5] = '{rv: 4'b1111, wv: 4'b1111, delay: 0, grant: 2, is_rd: 1, addr: 8'h10, data: 16'h1234};
        vt[6] = '{rv: 4'b0000, wv: 4'b0001, delay: 3, grant: 0, is_rd: 0, addr: 8'h50, data: 16'hA000};
        vt[7] = '{rv: 4'b0000, wv: 4'b1000, delay: 0, grant: 3, is_rd: 0, addr: 8'h70, data: 16'hA003};

        reset                 = 1'b0;
        bus.lsu_read_valid    = '0;
        bus.lsu_write_valid   = '0;
        bus.lsu_read_address  = {8'h33, 8'h10, 8'h05, 8'h40};
        bus.lsu_write_address = {8'h70, 8'h60, 8'h06, 8'h50};
        bus.lsu_write_data    = {16'hA003, 16'hA002, 16'hBEEF, 16'hA000};
        bus.mem_read_ready    = 1'b0;
        bus.mem_read_data     = '0;
        bus.mem_write_ready   = 1'b0;

        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_idx}, 0);
        chk("rst_mem_valids", {30'd0, bus.mem_read_valid, bus.mem_write_valid}, 0);
        chk("rst_readies", {24'd0, bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        chk("rst_addrs", {16'd0, bus.mem_read_address, bus.mem_write_address}, 0);
        chk("rst_data", {bus.mem_write_data, bus.lsu_read_data}, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // All four read together after reset, memory always ready.
        reset = 1'b0;
        repeat (2) tick();
        reset              = 1'b1;
        bus.mem_read_ready = 1'b1;
        bus.lsu_read_valid = 4'b1111;
        k    = 0;
        last = -1;
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            tick();
            if (bus.lsu_read_ready != 4'b0000) begin
                chk("rr_order", {28'd0, bus.lsu_read_ready}, 32'(4'(1) << k));
                if (k == 0) chk("first_latency", cyc, 1);
                else chk("pulse_spacing", cyc - last, 3);
                last = cyc;
                bus.lsu_read_valid[k] = 1'b0;
                k++;
            end
        end
        if (k < 4) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout actual=%0d expected=4", k);
        end
        bus.mem_read_ready = 1'b0;
        bus.lsu_read_valid = '0;
        repeat (2) tick();

        // Reset landing while a read is outstanding.
        bus.lsu_read_valid = 4'b1100;
        n = 0;
        while (!bus.mem_read_valid && n < 20) begin
            tick();
            n++;
        end
        chk("pre_reset_grant", {30'd0, grant_idx}, 2);
        reset              = 1'b0;
        bus.mem_read_ready = 1'b1;
        tick();
        chk("midrst_mem_read_valid", {31'd0, bus.mem_read_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_no_ready", {28'd0, bus.lsu_read_ready}, 0);
        chk("midrst_grant", {30'd0, grant_idx}, 0);
        chk("midrst_addr_data", {8'd0, bus.mem_read_address, bus.lsu_read_data}, 0);
        bus.mem_read_ready = 1'b0;
        reset              = 1'b1;
        bus.lsu_read_valid = 4'b1111;
        n = 0;
        while (!bus.mem_read_valid && n < 20) begin
            tick();
            n++;
        end
        chk("post_reset_grant", {30'd0, grant_idx}, 0);
        chk("post_reset_addr", {24'd0, bus.mem_read_address}, 32'h40);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'h0F0F;
        tick();
        bus.mem_read_ready = 1'b0;
        chk("post_reset_ready", {28'd0, bus.lsu_read_ready}, 1);
        chk("post_reset_data", {16'd0, bus.lsu_read_data}, 32'h0F0F);
        bus.lsu_read_valid = '0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_arbiter.md
LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 Parameter NUM_LSUS, default 4, number of LSU requesters sharing one data-memory port (2..16).
REQ-002 Parameter ADDR_BITS, default 8, data-memory address width.
REQ-003 Parameter DATA_BITS, default 16, data word width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 lsu_read_valid  in  NUM_LSUS  per-LSU read request, held until that LSU's read ready.
REQ-007 lsu_read_address  in  NUM_LSUS*ADDR_BITS  per-LSU read address; slice i belongs to LSU i.
REQ-008 lsu_read_ready  out  NUM_LSUS  one-hot, one-cycle read completion pulse.
REQ-009 lsu_read_data  out  DATA_BITS  read data, broadcast; valid while lsu_read_ready has a bit set.
REQ-010 lsu_write_valid  in  NUM_LSUS  per-LSU write request, held until that LSU's write ready.
REQ-011 lsu_write_address  in  NUM_LSUS*ADDR_BITS  per-LSU write address.
REQ-012 lsu_write_data  in  NUM_LSUS*DATA_BITS  per-LSU write data.
REQ-013 lsu_write_ready  out  NUM_LSUS  one-hot, one-cycle write completion pulse.
REQ-014 mem_read_valid / mem_read_address / mem_read_ready / mem_read_data  out/out/in/in  1/ADDR_BITS/1/DATA_BITS  shared memory read channel.
REQ-015 mem_write_valid / mem_write_address / mem_write_data / mem_write_ready  out/out/out/in  1/ADDR_BITS/DATA_BITS/1  shared memory write channel.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 grant_idx  out  $clog2(NUM_LSUS)  index of the LSU currently owning the memory port.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States SHALL be IDLE, READ_WAIT, WRITE_WAIT, DONE; at most one memory transaction outstanding.
REQ-020 Round-robin pointer rr_ptr SHALL select the first LSU i, searching rr_ptr, rr_ptr+1, ... modulo NUM_LSUS, whose read_valid or write_valid is high.
REQ-021 IDLE, request found: latch grant_idx=i; if read_valid[i] set mem_read_valid=1, mem_read_address=slice i, go READ_WAIT; else set mem_write_valid=1, address/data=slice i, go WRITE_WAIT.
REQ-022 When one LSU asserts read and write together, the read SHALL be served first; the write is served on a later grant.
REQ-023 IDLE, no request: outputs unchanged, stay IDLE.
REQ-024 READ_WAIT: while mem_read_ready=0 hold mem_read_valid and address; when mem_read_ready=1 clear mem_read_valid, register lsu_read_data=mem_read_data, set lsu_read_ready[grant_idx]=1, go DONE.
REQ-025 WRITE_WAIT: on mem_write_ready=1 clear mem_write_valid, set lsu_write_ready[grant_idx]=1, go DONE.
REQ-026 On completion rr_ptr SHALL become (grant_idx+1) mod NUM_LSUS, wrapping NUM_LSUS-1 to 0.
REQ-027 DONE: clear all lsu_*_ready bits, return to IDLE; lasts exactly one cycle so the served LSU drops its valid before re-arbitration.
REQ-028 Ready pulses SHALL be exactly one cycle and never target a non-granted LSU.
REQ-029 Minimum request-to-ready latency SHALL be 2 cycles (IDLE grant, WAIT with ready=1); minimum grant-to-grant spacing 3 cycles.
REQ-030 Request valids changing during READ_WAIT/WRITE_WAIT SHALL NOT affect the granted transaction.
REQ-031 lsu_read_data SHALL hold its last value outside ready pulses.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, rr_ptr=0, grant_idx=0, busy=0, all valid/ready outputs 0, all address/data outputs 0, regardless of state, including mid-transaction.
REQ-033 After reset, first arbitration SHALL favour LSU 0.

Verification
REQ-034 Single read: LSU2 read addr 0x10, memory returns 0x1234 with ready 2 cycles after valid -> one mem_read_valid burst addr 0x10, lsu_read_ready=4'b0100 for one cycle, lsu_read_data=0x1234.
REQ-035 All four LSUs request reads together after reset, memory ready immediately -> grants in order 0,1,2,3, each ready pulse 3 cycles apart.
REQ-036 rr_ptr=3, LSU3 and LSU0 request -> LSU3 served first, then LSU0 (wrap).
REQ-037 LSU1 asserts read addr 0x05 and write addr 0x06 data 0xBEEF together -> read completes first, write on subsequent grant with mem_write_data=0xBEEF.
REQ-038 reset=0 during READ_WAIT -> next cycle mem_read_valid=0, busy=0, no lsu_read_ready pulse; after release LSU0 gets first grant.
